// File: rtl/instr_prefetch_queue.sv
// Credit-limited instruction prefetcher feeding a first-word-fall-through queue.
// Reads are only issued while queued words plus in-flight reads leave room for one more.
module instr_prefetch_queue #(
    parameter int INSTR_WIDTH = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int RD_LATENCY  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [CNT_WIDTH-1:0]   instr_count,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd_en,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [INSTR_WIDTH-1:0] deq_instr,
    output logic [$clog2(DEPTH):0] fill_level
);
    localparam int PW  = $clog2(DEPTH);
    localparam int FW  = PW + 1;
    localparam int IFW = $clog2(RD_LATENCY + 2);
    localparam int OW  = ((FW > IFW) ? FW : IFW) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_n;
    logic [RD_LATENCY:0]     vld_pipe;
    logic [IFW-1:0]          in_flight;
    logic [OW-1:0]           occ;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [CNT_WIDTH-1:0]    remaining;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [INSTR_WIDTH-1:0]  ram [DEPTH];
    logic                    issue, push, pop;

    // vld_pipe[0] is the registered read strobe; the tail bit marks returning data.
    assign mem_rd_en = vld_pipe[0];
    assign push      = vld_pipe[RD_LATENCY];
    assign deq_valid = (fill_level != '0);
    assign pop       = deq_valid && deq_ready;
    assign deq_instr = ram[rd_ptr];

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= RD_LATENCY; i++)
            in_flight = in_flight + IFW'(vld_pipe[i]);
        occ = OW'(fill_level) + OW'(in_flight);
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        issue   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_n = (instr_count != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                busy  = 1'b1;
                issue = (remaining != '0) && (occ < OW'(DEPTH));
                if (issue && remaining == CNT_WIDTH'(1))
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (in_flight == '0)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            vld_pipe   <= '0;
            mem_addr   <= '0;
            next_addr  <= '0;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (flush) begin
            // Clearing the pipe makes any data still returning from memory fall on the floor.
            state      <= S_IDLE;
            done       <= 1'b0;
            vld_pipe   <= '0;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            state       <= state_n;
            done        <= (state == S_DONE);
            vld_pipe[0] <= issue;
            for (int i = 1; i <= RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (issue) begin
                mem_addr  <= next_addr;
                next_addr <= next_addr + ADDR_WIDTH'(1);
                remaining <= remaining - CNT_WIDTH'(1);
            end
            if (state == S_IDLE && start) begin
                next_addr <= start_addr;
                remaining <= instr_count;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fill_level <= fill_level + FW'(1);
                2'b01:   fill_level <= fill_level - FW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ram[wr_ptr] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push)
            assert (fill_level != FW'(DEPTH))
            else $error("instr_prefetch_queue: push into full queue");
    end
endmodule
